// File: rtl/sprite_line_engine.sv
// Per-scanline sprite engine: scans the attribute RAM for sprites on the next row, then streams their pixels to the line buffer.
// Optional feature: define SPRITE_VFLIP_EN to honour attribute bit 29 (vertical flip).
module sprite_line_engine #(
  parameter int NUM_SPRITE = 32,
  parameter int MAX_SLOT   = 8,
  parameter int SPR_W      = 16,
  parameter int SPR_H      = 16,
  parameter int COLOR_W    = 16,
  parameter int H_RES      = 640,
  parameter int V_RES      = 480,
  parameter int V_TOTAL    = 525,
  parameter logic [COLOR_W-1:0] TRANSP_KEY = '0,
  localparam int IW  = $clog2(NUM_SPRITE),
  localparam int SW  = $clog2(SPR_W),
  localparam int RW  = $clog2(SPR_H),
  localparam int AW  = 8 + SW + RW,
  localparam int SPW = (MAX_SLOT > 1) ? $clog2(MAX_SLOT) : 1,
  localparam int SLW = $clog2(MAX_SLOT + 1)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               line_start,
  input  logic [9:0]         vcount,
  input  logic               spr_wr_en,
  input  logic [IW-1:0]      spr_wr_idx,
  input  logic [31:0]        spr_wr_data,
  output logic [AW-1:0]      rom_addr,
  input  logic [COLOR_W-1:0] rom_q,
  output logic [9:0]         pix_col,
  output logic [COLOR_W-1:0] pix_data,
  output logic               pix_wren,
  output logic               overflow,
  output logic               done
);

  // state | meaning
  // IDLE  | waiting for line_start, done=1
  // SCAN  | reading attributes 0..NUM_SPRITE-1, filling slots in index order
  // DRAW  | issuing ROM addresses, highest filled slot first
  // FIN   | line complete, done=1
  typedef enum logic [1:0] {IDLE, SCAN, DRAW, FIN} state_t;

  localparam logic [9:0]     VRES10   = 10'(V_RES);
  localparam logic [9:0]     VLAST10  = 10'(V_TOTAL - 1);
  localparam logic [10:0]    HRES11   = 11'(H_RES);
  localparam logic [IW:0]    LAST_IDX = (IW+1)'(NUM_SPRITE);
  localparam logic [SLW-1:0] MAXS     = SLW'(MAX_SLOT);

  state_t         state_q;
  logic [31:0]    attr_q [NUM_SPRITE];
  logic [31:0]    rd_q;
  logic [9:0]     tgt_q, tgt_d;
  logic [IW:0]    idx_q;
  logic [SLW-1:0] nslot_q, nfill_d;
  logic [SPW-1:0] sp_q;
  logic [SW-1:0]  x_q;
  logic [9:0]     s_col_q [MAX_SLOT];
  logic [7:0]     s_frm_q [MAX_SLOT];
  logic [RW-1:0]  s_row_q [MAX_SLOT];
  logic           s_hf_q  [MAX_SLOT];
  logic [AW-1:0]  rom_addr_q;
  logic           a_vld_q, b_vld_q, b_clip_q;
  logic [10:0]    a_col_q;
  logic [9:0]     pix_col_q;
  logic           overflow_q, done_q;

  logic [9:0]     row10, roff_full;
  logic [RW-1:0]  rowidx;
  logic           hit, take, blank_c, unused_attr;

  assign tgt_d     = (vcount == VLAST10) ? 10'd0 : vcount + 10'd1;
  assign blank_c   = (vcount >= VRES10 - 10'd1) && (vcount < VLAST10);
  assign row10     = {1'b0, rd_q[26:18]};
  assign roff_full = tgt_q - row10;
  assign hit       = rd_q[31] && (tgt_q >= row10) && (tgt_q < row10 + 10'(SPR_H));
  assign take      = hit && (idx_q != '0) && (nslot_q < MAXS);
  assign nfill_d   = nslot_q + SLW'(take);

`ifdef SPRITE_VFLIP_EN
  assign rowidx      = rd_q[29] ? ~roff_full[RW-1:0] : roff_full[RW-1:0];
  assign unused_attr = ^{rd_q[28:27], roff_full[9:RW]};
`else
  assign rowidx      = roff_full[RW-1:0];
  assign unused_attr = ^{rd_q[29:27], roff_full[9:RW]};
`endif

  // Registered read gives old data on a same-index write.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_SPRITE; i++) attr_q[i] <= '0;
    end else if (spr_wr_en) begin
      attr_q[spr_wr_idx] <= spr_wr_data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      rd_q       <= '0;
      tgt_q      <= '0;
      idx_q      <= '0;
      nslot_q    <= '0;
      sp_q       <= '0;
      x_q        <= '0;
      rom_addr_q <= '0;
      a_vld_q    <= 1'b0;
      a_col_q    <= '0;
      b_vld_q    <= 1'b0;
      b_clip_q   <= 1'b0;
      pix_col_q  <= '0;
      overflow_q <= 1'b0;
      done_q     <= 1'b1;
      for (int i = 0; i < MAX_SLOT; i++) begin
        s_col_q[i] <= '0;
        s_frm_q[i] <= '0;
        s_row_q[i] <= '0;
        s_hf_q[i]  <= 1'b0;
      end
    end else begin
      rd_q     <= attr_q[idx_q[IW-1:0]];
      a_vld_q  <= 1'b0;
      b_vld_q  <= a_vld_q;
      b_clip_q <= (a_col_q >= HRES11);
      if (a_vld_q) pix_col_q <= a_col_q[9:0];
      case (state_q)
        IDLE: begin
          done_q <= 1'b1;
          if (line_start) begin
            overflow_q <= 1'b0;
            if (tgt_d < VRES10) begin
              state_q <= SCAN;
              done_q  <= blank_c;
              tgt_q   <= tgt_d;
              idx_q   <= '0;
              nslot_q <= '0;
            end
          end
        end
        SCAN: begin
          idx_q  <= idx_q + 1'b1;
          done_q <= blank_c;
          if (take) begin
            s_col_q[nslot_q[SPW-1:0]] <= rd_q[17:8];
            s_frm_q[nslot_q[SPW-1:0]] <= rd_q[7:0];
            s_row_q[nslot_q[SPW-1:0]] <= rowidx;
            s_hf_q[nslot_q[SPW-1:0]]  <= rd_q[30];
            nslot_q <= nfill_d;
          end else if (hit && idx_q != '0) begin
            overflow_q <= 1'b1;
          end
          if (idx_q == LAST_IDX) begin
            if (nfill_d == '0) begin
              state_q <= FIN;
              done_q  <= 1'b1;
            end else begin
              state_q <= DRAW;
              sp_q    <= SPW'(nfill_d - 1'b1);
              x_q     <= '0;
            end
          end
        end
        DRAW: begin
          rom_addr_q <= {s_frm_q[sp_q], s_row_q[sp_q], s_hf_q[sp_q] ? ~x_q : x_q};
          a_vld_q    <= 1'b1;
          a_col_q    <= {1'b0, s_col_q[sp_q]} + {{(11-SW){1'b0}}, x_q};
          done_q     <= blank_c;
          x_q        <= x_q + 1'b1;
          if (x_q == SW'(SPR_W - 1)) begin
            if (sp_q == '0) begin
              state_q <= FIN;
              done_q  <= 1'b1;
            end else begin
              sp_q <= sp_q - 1'b1;
            end
          end
        end
        default: begin
          state_q <= IDLE;
          done_q  <= 1'b1;
        end
      endcase
    end
  end

  assign rom_addr = rom_addr_q;
  assign pix_col  = pix_col_q;
  assign pix_data = b_vld_q ? rom_q : '0;
  assign pix_wren = b_vld_q && !b_clip_q && (rom_q != TRANSP_KEY);
  assign overflow = overflow_q;
  assign done     = done_q;

endmodule

// File: tb/tb_sprite_line_engine.sv
// Self-checking bench for sprite_line_engine: behavioural ROM, attribute mirror and write scoreboard.
module tb_sprite_line_engine;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        line_start = 1'b0;
  logic [9:0]  vcount = '0;
  logic        spr_wr_en = 1'b0;
  logic [4:0]  spr_wr_idx = '0;
  logic [31:0] spr_wr_data = '0;
  logic [15:0] rom_addr;
  logic [15:0] rom_q = '0;
  logic [9:0]  pix_col;
  logic [15:0] pix_data;
  logic        pix_wren;
  logic        overflow;
  logic        done;

  int errors = 0;
  int checks = 0;
  bit mon_en = 1'b1;
  logic [25:0] exp_q [$];
  logic [15:0] lb [1024];

  bit       m_en  [32];
  bit       m_hf  [32];
  bit       m_vf  [32];
  int       m_row [32];
  int       m_col [32];
  int       m_frm [32];

  sprite_line_engine dut (
    .clk(clk), .reset(reset), .line_start(line_start), .vcount(vcount),
    .spr_wr_en(spr_wr_en), .spr_wr_idx(spr_wr_idx), .spr_wr_data(spr_wr_data),
    .rom_addr(rom_addr), .rom_q(rom_q), .pix_col(pix_col), .pix_data(pix_data),
    .pix_wren(pix_wren), .overflow(overflow), .done(done)
  );

  always #5 clk = ~clk;

  // Frame 2 has transparent pixels at even ROM x.
  function automatic logic [15:0] rom_fn(input logic [15:0] a);
    logic [15:0] v;
    v = {4'hA, a[11:0]};
    if (a[15:8] == 8'd2 && a[0] == 1'b0) v = '0;
    return v;
  endfunction

  always @(posedge clk) rom_q <= rom_fn(rom_addr);

  always @(negedge clk) begin
    if (mon_en && pix_wren) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write col=%0d data=%h (none expected)", pix_col, pix_data);
      end else begin
        logic [25:0] e;
        e = exp_q.pop_front();
        if ({pix_col, pix_data} !== e) begin
          errors++;
          $display("FAIL write_seq got col=%0d data=%h want col=%0d data=%h",
                   pix_col, pix_data, e[25:16], e[15:0]);
        end
      end
      lb[pix_col] = pix_data;
    end
  end

  task automatic write_attr(input int idx, input bit en, input bit hf, input bit vf,
                            input int row, input int col, input int frm);
    @(posedge clk); #1;
    spr_wr_en   = 1'b1;
    spr_wr_idx  = 5'(idx);
    spr_wr_data = {en, hf, vf, 2'b00, 9'(row), 10'(col), 8'(frm)};
    @(posedge clk); #1;
    spr_wr_en = 1'b0;
    m_en[idx] = en; m_hf[idx] = hf; m_vf[idx] = vf;
    m_row[idx] = row; m_col[idx] = col; m_frm[idx] = frm;
  endtask

  task automatic clear_attrs();
    for (int i = 0; i < 32; i++) write_attr(i, 1'b0, 1'b0, 1'b0, 0, 0, 0);
  endtask

  task automatic push_line(input int vc, output bit ovf);
    int tgt;
    int hits[$];
    int nhit;
    tgt = (vc == 524) ? 0 : vc + 1;
    ovf = 1'b0;
    nhit = 0;
    if (tgt < 480) begin
      for (int i = 0; i < 32; i++)
        if (m_en[i] && tgt >= m_row[i] && tgt < m_row[i] + 16) begin
          nhit++;
          if (hits.size() < 8) hits.push_back(i);
        end
      ovf = (nhit > 8);
      for (int s = hits.size() - 1; s >= 0; s--) begin
        int i, r, ri;
        i = hits[s];
        r = tgt - m_row[i];
        ri = r;
`ifdef SPRITE_VFLIP_EN
        if (m_vf[i]) ri = 15 - r;
`endif
        for (int x = 0; x < 16; x++) begin
          int xi, c;
          logic [15:0] a, d;
          xi = m_hf[i] ? 15 - x : x;
          a = 16'(m_frm[i] * 256 + ri * 16 + xi);
          d = rom_fn(a);
          c = m_col[i] + x;
          if (d != 16'd0 && c < 640) exp_q.push_back({10'(c), d});
        end
      end
    end
  endtask

  task automatic run_line(input int vc, output int cyc);
    @(posedge clk); #1;
    vcount = 10'(vc);
    line_start = 1'b1;
    @(posedge clk); #1;
    line_start = 1'b0;
    cyc = 0;
    while (done == 1'b0 && cyc < 3000) begin
      @(posedge clk); #1;
      cyc++;
    end
    checks++;
    if (cyc >= 3000) begin
      errors++;
      $display("FAIL done_timeout cycles=%0d limit=3000", cyc);
    end
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL missing_writes remaining=%0d want 0 (vcount=%0d)", exp_q.size(), vc);
      exp_q.delete();
    end
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({pix_wren, pix_col, pix_data, rom_addr, overflow, done} !== {1'b0, 10'd0, 16'd0, 16'd0, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL reset_values got wren=%b col=%0d data=%h addr=%h ovf=%b done=%b want 0 0 0 0 0 1",
               pix_wren, pix_col, pix_data, rom_addr, overflow, done);
    end
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("FAIL idle_done got=%b want=1", done);
    end
  endtask

  task automatic test_empty();
    int cyc;
    bit ovf;
    push_line(10, ovf);
    run_line(10, cyc);
    checks++;
    if (cyc > 35 || cyc < 1) begin
      errors++;
      $display("FAIL empty_done_latency got=%0d want 1..35", cyc);
    end
  endtask

  task automatic test_single();
    int cyc;
    bit ovf;
    write_attr(0, 1'b1, 1'b0, 1'b0, 33, 0, 1);
    push_line(32, ovf);
    checks++;
    if (exp_q.size() != 16 || exp_q[0] !== {10'd0, rom_fn(16'h0100)} || exp_q[15] !== {10'd15, rom_fn(16'h010F)}) begin
      errors++;
      $display("FAIL single_model entries=%0d want 16", exp_q.size());
    end
    run_line(32, cyc);
    write_attr(0, 1'b1, 1'b1, 1'b0, 33, 0, 1);
    push_line(32, ovf);
    run_line(32, cyc);
    checks++;
    if (lb[0] !== rom_fn(16'h010F)) begin
      errors++;
      $display("FAIL hflip_col0 got=%h want=%h", lb[0], rom_fn(16'h010F));
    end
  endtask

  task automatic test_overflow();
    int cyc;
    bit ovf;
    clear_attrs();
    for (int i = 0; i < 10; i++) write_attr(i, 1'b1, 1'b0, 1'b0, 100, 20 * i, i + 1);
    push_line(100, ovf);
    run_line(100, cyc);
    checks++;
    if (overflow !== ovf || ovf !== 1'b1) begin
      errors++;
      $display("FAIL overflow_set got=%b want=1", overflow);
    end
    repeat (5) @(posedge clk);
    #1;
    checks++;
    if (overflow !== 1'b1) begin
      errors++;
      $display("FAIL overflow_hold got=%b want=1", overflow);
    end
    push_line(200, ovf);
    run_line(200, cyc);
    checks++;
    if (overflow !== 1'b0) begin
      errors++;
      $display("FAIL overflow_clear got=%b want=0", overflow);
    end
  endtask

  task automatic test_priority();
    int cyc;
    bit ovf;
    clear_attrs();
    write_attr(0, 1'b1, 1'b0, 1'b0, 100, 50, 2);
    write_attr(1, 1'b1, 1'b0, 1'b0, 100, 50, 3);
    push_line(100, ovf);
    run_line(100, cyc);
    checks++;
    if (lb[50] !== rom_fn(16'h0310)) begin
      errors++;
      $display("FAIL transparent_shows_idx1 got=%h want=%h", lb[50], rom_fn(16'h0310));
    end
    checks++;
    if (lb[51] !== rom_fn(16'h0211)) begin
      errors++;
      $display("FAIL idx0_wins got=%h want=%h", lb[51], rom_fn(16'h0211));
    end
  endtask

  task automatic test_boundary();
    int cyc;
    bit ovf;
    clear_attrs();
    write_attr(0, 1'b1, 1'b0, 1'b0, 300, 632, 4);
    push_line(300, ovf);
    run_line(300, cyc);
    write_attr(5, 1'b1, 1'b0, 1'b1, 0, 100, 5);
    push_line(524, ovf);
    run_line(524, cyc);
    push_line(479, ovf);
    run_line(479, cyc);
    checks++;
    if (done !== 1'b1 || cyc != 0) begin
      errors++;
      $display("FAIL blank_line_done got done=%b cycles=%0d want done=1 cycles=0", done, cyc);
    end
  endtask

  task automatic test_reset_mid_draw();
    int n;
    int cyc;
    bit ovf;
    write_attr(1, 1'b1, 1'b0, 1'b0, 300, 200, 6);
    push_line(300, ovf);
    @(posedge clk); #1;
    vcount = 10'd300;
    line_start = 1'b1;
    @(posedge clk); #1;
    line_start = 1'b0;
    n = 0;
    while (pix_wren !== 1'b1 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (n >= 200) begin
      errors++;
      $display("FAIL draw_start_timeout cycles=%0d limit=200", n);
    end
    mon_en = 1'b0;
    reset = 1'b0;
    #1;
    checks++;
    if (pix_wren !== 1'b0 || done !== 1'b1 || rom_addr !== 16'd0) begin
      errors++;
      $display("FAIL reset_abort got wren=%b done=%b addr=%h want 0 1 0000", pix_wren, done, rom_addr);
    end
    exp_q.delete();
    for (int i = 0; i < 32; i++) m_en[i] = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    mon_en = 1'b1;
    push_line(300, ovf);
    run_line(300, cyc);
  endtask

  initial begin
    test_reset();
    test_empty();
    test_single();
    test_overflow();
    test_priority();
    test_boundary();
    test_reset_mid_draw();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
